// File: rtl/arp_frame_deser.sv
// Purpose : packs an Ethernet header handshake plus its 8-bit AXI-stream payload into one
//           left-aligned frame word {dest, src, type, payload} with stored length and error flag.
// Latency : m_frame_valid rises the cycle after the tlast beat is accepted; the next header is
//           accepted one cycle after the output handshake.
// Backpressure: the output word is held stable while m_frame_ready is low; header and payload
//           inputs are not accepted until the word has been taken.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   s_eth_hdr_*                         header handshake (dest MAC, src MAC, EtherType)
//   s_eth_payload_axis_*                payload byte stream (tkeep gates storage, tuser = bad frame)
//   m_frame_valid / m_frame_ready       packed frame handshake
//   m_frame_data / _len / _error        packed frame word, stored byte count, short/long/bad flag
//
// Optional: define ARP_FRAME_TYPE_FILTER_EN to silently consume frames whose EtherType is not
//           FILTER_TYPE (no output is produced for them).

module arp_frame_deser #(
    parameter int          PAYLOAD_BYTES = 28,
    parameter logic [15:0] FILTER_TYPE   = 16'h0806,
    localparam int         TOTAL_WIDTH   = 112 + 8 * PAYLOAD_BYTES,
    localparam int         LEN_WIDTH     = $clog2(PAYLOAD_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   s_eth_hdr_valid,
    output logic                   s_eth_hdr_ready,
    input  logic [47:0]            s_eth_dest_mac,
    input  logic [47:0]            s_eth_src_mac,
    input  logic [15:0]            s_eth_type,

    input  logic [7:0]             s_eth_payload_axis_tdata,
    input  logic                   s_eth_payload_axis_tkeep,
    input  logic                   s_eth_payload_axis_tvalid,
    output logic                   s_eth_payload_axis_tready,
    input  logic                   s_eth_payload_axis_tlast,
    input  logic                   s_eth_payload_axis_tuser,

    output logic                   m_frame_valid,
    input  logic                   m_frame_ready,
    output logic [TOTAL_WIDTH-1:0] m_frame_data,
    output logic [LEN_WIDTH-1:0]   m_frame_len,
    output logic                   m_frame_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0] CAP = LEN_WIDTH'(PAYLOAD_BYTES);

    state_t               state;
    logic [LEN_WIDTH-1:0] idx;
    logic                 err;

    // drop marks a frame that is consumed but never presented (filter build only)
`ifdef ARP_FRAME_TYPE_FILTER_EN
    logic                 drop;
`else
    logic                 drop;
    assign drop = 1'b0;
`endif

    logic                 beat_fire;
    logic                 room;
    logic                 store;
    logic                 overflow;
    logic [LEN_WIDTH-1:0] idx_next;

    // tready is only ever high in PAYLOAD, so beat_fire implies PAYLOAD
    assign beat_fire = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
    assign room      = (idx < CAP);
    assign store     = beat_fire && s_eth_payload_axis_tkeep && room && !drop;
    assign overflow  = beat_fire && s_eth_payload_axis_tkeep && !room;
    assign idx_next  = store ? idx + LEN_WIDTH'(1) : idx;

    assign m_frame_error = err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                     <= IDLE;
            s_eth_hdr_ready           <= 1'b0;
            s_eth_payload_axis_tready <= 1'b0;
            m_frame_valid             <= 1'b0;
            m_frame_data              <= '0;
            m_frame_len               <= '0;
            err                       <= 1'b0;
            idx                       <= '0;
`ifdef ARP_FRAME_TYPE_FILTER_EN
            drop                      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    s_eth_hdr_ready <= 1'b1;
                    if (s_eth_hdr_valid && s_eth_hdr_ready) begin
                        s_eth_hdr_ready           <= 1'b0;
                        s_eth_payload_axis_tready <= 1'b1;
                        idx                       <= '0;
                        err                       <= 1'b0;
                        state                     <= PAYLOAD;
`ifdef ARP_FRAME_TYPE_FILTER_EN
                        drop <= (s_eth_type != FILTER_TYPE);
                        if (s_eth_type == FILTER_TYPE) begin
                            m_frame_data <= {s_eth_dest_mac, s_eth_src_mac, s_eth_type,
                                             {(8 * PAYLOAD_BYTES){1'b0}}};
                        end
`else
                        m_frame_data <= {s_eth_dest_mac, s_eth_src_mac, s_eth_type,
                                         {(8 * PAYLOAD_BYTES){1'b0}}};
`endif
                    end
                end

                PAYLOAD: begin
                    if (beat_fire) begin
                        // byte i lands just below the header, walking towards the LSBs
                        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                            if (store && idx == LEN_WIDTH'(i)) begin
                                m_frame_data[TOTAL_WIDTH-113-8*i -: 8] <= s_eth_payload_axis_tdata;
                            end
                        end
                        idx <= idx_next;

                        if (s_eth_payload_axis_tlast) begin
                            s_eth_payload_axis_tready <= 1'b0;
                            if (drop) begin
                                s_eth_hdr_ready <= 1'b1;
                                state           <= IDLE;
                            end else begin
                                m_frame_len   <= idx_next;
                                err           <= err | overflow | s_eth_payload_axis_tuser |
                                                 (idx_next < CAP);
                                m_frame_valid <= 1'b1;
                                state         <= OUTPUT;
                            end
                        end else begin
                            err <= err | overflow;
                        end
                    end
                end

                OUTPUT: begin
                    if (m_frame_ready) begin
                        m_frame_valid   <= 1'b0;
                        s_eth_hdr_ready <= 1'b1;
                        state           <= IDLE;
                    end
                end

                default: begin
                    state                     <= IDLE;
                    s_eth_hdr_ready           <= 1'b0;
                    s_eth_payload_axis_tready <= 1'b0;
                    m_frame_valid             <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arp_frame_deser.sv
// Purpose : randomized self-checking bench for arp_frame_deser against a frame-level model.
// Latency : checks valid one cycle after tlast and header ready one cycle after the handshake.
// Backpressure: holds m_frame_ready low for a chosen number of cycles and checks stability.

module tb_arp_frame_deser;

    localparam int PB = 28;
    localparam int TW = 112 + 8 * PB;
    localparam int LW = $clog2(PB + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_eth_hdr_valid = 1'b0;
    logic          s_eth_hdr_ready;
    logic [47:0]   s_eth_dest_mac = '0;
    logic [47:0]   s_eth_src_mac = '0;
    logic [15:0]   s_eth_type = '0;
    logic [7:0]    tdata = '0;
    logic          tkeep = 1'b0;
    logic          tvalid = 1'b0;
    logic          tready;
    logic          tlast = 1'b0;
    logic          tuser = 1'b0;
    logic          m_frame_valid;
    logic          m_frame_ready = 1'b0;
    logic [TW-1:0] m_frame_data;
    logic [LW-1:0] m_frame_len;
    logic          m_frame_error;

    arp_frame_deser dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .s_eth_hdr_valid           (s_eth_hdr_valid),
        .s_eth_hdr_ready           (s_eth_hdr_ready),
        .s_eth_dest_mac            (s_eth_dest_mac),
        .s_eth_src_mac             (s_eth_src_mac),
        .s_eth_type                (s_eth_type),
        .s_eth_payload_axis_tdata  (tdata),
        .s_eth_payload_axis_tkeep  (tkeep),
        .s_eth_payload_axis_tvalid (tvalid),
        .s_eth_payload_axis_tready (tready),
        .s_eth_payload_axis_tlast  (tlast),
        .s_eth_payload_axis_tuser  (tuser),
        .m_frame_valid             (m_frame_valid),
        .m_frame_ready             (m_frame_ready),
        .m_frame_data              (m_frame_data),
        .m_frame_len               (m_frame_len),
        .m_frame_error             (m_frame_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // beat stream of the frame under test
    logic [7:0] bq[$];
    bit         kq[$];

    task automatic check_all_zero(input string tag);
        check({tag, "_vld"},  TW'(m_frame_valid),   '0);
        check({tag, "_dat"},  m_frame_data,         '0);
        check({tag, "_len"},  TW'(m_frame_len),     '0);
        check({tag, "_err"},  TW'(m_frame_error),   '0);
        check({tag, "_hrdy"}, TW'(s_eth_hdr_ready), '0);
        check({tag, "_trdy"}, TW'(tready),          '0);
    endtask

    // Sends one frame and checks the packed result. Enters and leaves just after a negedge.
    // rst_after >= 0 asserts reset once that many beats have been accepted.
    task automatic run_frame(input string tag, input logic [47:0] d, input logic [47:0] s,
                             input logic [15:0] t, input int stall, input bit gaps,
                             input bit user, input int rst_after);
        logic [7:0]      st[$];
        int              kept = 0;
        bit              exp_err, drop;
        logic [8*PB-1:0] pay = '0;
        logic [TW-1:0]   exp_dat, held;
        int              g;

        // frame-level model: first PB kept bytes are stored, everything else is lost
        foreach (bq[i]) if (kq[i]) begin
            if (kept < PB) st.push_back(bq[i]);
            kept++;
        end
        for (int i = 0; i < PB; i++) pay = {pay[8*PB-9:0], (i < st.size()) ? st[i] : 8'h00};
        exp_dat = {d, s, t, pay};
        exp_err = user || (kept != PB);
`ifdef ARP_FRAME_TYPE_FILTER_EN
        drop = (t != 16'h0806);
`else
        drop = 1'b0;
`endif

        s_eth_dest_mac = d; s_eth_src_mac = s; s_eth_type = t; s_eth_hdr_valid = 1'b1;
        g = 0;
        while (!s_eth_hdr_ready && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) check({tag, "_hdr_timeout"}, '0, TW'(1));
        @(negedge clk);
        s_eth_hdr_valid = 1'b0;

        for (int i = 0; i < bq.size(); i++) begin
            if (i == rst_after) begin
                rst_n = 1'b0;
                #1 check_all_zero({tag, "_rst"});
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check({tag, "_rst_hrdy"}, TW'(s_eth_hdr_ready), TW'(1));
                return;
            end
            if (gaps && ($urandom % 3 == 0)) @(negedge clk);
            tvalid = 1'b1; tdata = bq[i]; tkeep = kq[i];
            tlast = (i == bq.size() - 1);
            tuser = user && tlast;
            g = 0;
            while (!tready && g < 50) begin @(negedge clk); g++; end
            if (g >= 50) check({tag, "_beat_timeout"}, '0, TW'(1));
            @(negedge clk);
            tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
        end

        if (drop) begin
            check({tag, "_drop_vld"},  TW'(m_frame_valid),   '0);
            check({tag, "_drop_hrdy"}, TW'(s_eth_hdr_ready), TW'(1));
            return;
        end

        check({tag, "_vld"}, TW'(m_frame_valid), TW'(1));
        check({tag, "_dat"}, m_frame_data,       exp_dat);
        check({tag, "_len"}, TW'(m_frame_len),   TW'(st.size()));
        check({tag, "_err"}, TW'(m_frame_error), TW'(exp_err));
        held = m_frame_data;
        for (int c = 0; c < stall; c++) begin
            @(negedge clk);
            check({tag, "_stall_vld"},  TW'(m_frame_valid),   TW'(1));
            check({tag, "_stall_dat"},  m_frame_data,         held);
            check({tag, "_stall_len"},  TW'(m_frame_len),     TW'(st.size()));
            check({tag, "_stall_hrdy"}, TW'(s_eth_hdr_ready), '0);
            check({tag, "_stall_trdy"}, TW'(tready),          '0);
        end
        m_frame_ready = 1'b1;
        @(negedge clk);
        m_frame_ready = 1'b0;
        check({tag, "_post_vld"},  TW'(m_frame_valid),   '0);
        check({tag, "_post_hrdy"}, TW'(s_eth_hdr_ready), TW'(1));
    endtask

    task automatic load_arp();
        bq = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
               8'h5a, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'hc0, 8'ha8, 8'h01, 8'h65,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hc0, 8'ha8, 8'h01, 8'h64};
        kq = {};
        foreach (bq[i]) kq.push_back(1'b1);
    endtask

    task automatic load_rand(input int n, input bit all_keep);
        bq = {}; kq = {};
        for (int i = 0; i < n; i++) begin
            bq.push_back(8'($urandom));
            kq.push_back(all_keep ? 1'b1 : ($urandom % 8 != 0));
        end
    endtask

    localparam logic [47:0] BCAST = 48'hffff_ffff_ffff;
    localparam logic [47:0] SRC   = 48'h5a51_5253_5455;

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release_hrdy", TW'(s_eth_hdr_ready), TW'(1));

        load_arp();
        run_frame("arp_req", BCAST, SRC, 16'h0806, 0, 1'b0, 1'b0, -1);
        run_frame("backpressure", BCAST, SRC, 16'h0806, 10, 1'b0, 1'b0, -1);

        load_rand(20, 1'b1);
        run_frame("short", BCAST, SRC, 16'h0806, 1, 1'b0, 1'b0, -1);
        load_rand(30, 1'b1);
        run_frame("long", BCAST, SRC, 16'h0806, 0, 1'b0, 1'b0, -1);
        load_arp();
        run_frame("tuser", BCAST, SRC, 16'h0806, 0, 1'b0, 1'b1, -1);

        bq = '{8'h77}; kq = '{1'b0};
        run_frame("zero_len", BCAST, SRC, 16'h0806, 0, 1'b0, 1'b0, -1);

        load_rand(28, 1'b1);
        run_frame("mid_reset", BCAST, SRC, 16'h0806, 0, 1'b0, 1'b0, 10);
        load_arp();
        run_frame("after_reset", 48'h0102_0304_0506, SRC, 16'h0806, 0, 1'b0, 1'b0, -1);

        load_arp();
        run_frame("type_0800", BCAST, SRC, 16'h0800, 0, 1'b0, 1'b0, -1);
        run_frame("type_0806", BCAST, SRC, 16'h0806, 0, 1'b0, 1'b0, -1);

        for (int f = 0; f < 25; f++) begin
            load_rand($urandom_range(1, 32), ($urandom % 2 == 0));
            run_frame("rand",
                      {$urandom, 16'($urandom)}, {$urandom, 16'($urandom)},
                      ($urandom % 2 == 0) ? 16'h0806 : 16'($urandom),
                      $urandom_range(0, 3), ($urandom % 2 == 0), ($urandom % 6 == 0), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/arp_frame_deser.md
Name: arp_frame_deser

Overview:
- Receive-side counterpart of the frame serializer feeding the ARP block.
- Consumes an Ethernet header handshake plus an 8-bit AXI-stream payload, and packs them into one flat, left-aligned frame word (header in the MSBs, payload below it).
- The frame word carries length and error status and is presented on a valid/ready output.
- Sits on the ARP block's m_eth_* output, so the bench and checkers compare whole frames rather than bytes.

Parameters:
- PAYLOAD_BYTES, 28: payload capacity in bytes (ARP body is 28).
- FILTER_TYPE, 16'h0806: EtherType accepted when the filter feature is compiled in.
- Derived, not overridable: TOTAL_WIDTH = 112 + 8*PAYLOAD_BYTES (336 at default). LEN_WIDTH = $clog2(PAYLOAD_BYTES+1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_eth_hdr_valid  in  1  header valid.
- s_eth_hdr_ready  out  1  header ready.
- s_eth_dest_mac  in  48  destination MAC.
- s_eth_src_mac  in  48  source MAC.
- s_eth_type  in  16  EtherType.
- s_eth_payload_axis_tdata  in  8  payload byte.
- s_eth_payload_axis_tkeep  in  1  byte enable.
- s_eth_payload_axis_tvalid  in  1  beat valid.
- s_eth_payload_axis_tready  out  1  beat ready.
- s_eth_payload_axis_tlast  in  1  last beat.
- s_eth_payload_axis_tuser  in  1  frame bad (sampled on the last beat).
- m_frame_valid  out  1  packed frame valid.
- m_frame_ready  in  1  packed frame ready.
- m_frame_data  out  TOTAL_WIDTH  {dest, src, type, payload}; payload byte 0 sits immediately below type.
- m_frame_len  out  LEN_WIDTH  stored payload bytes.
- m_frame_error  out  1  short, long or tuser-flagged frame.

Behaviour:
- Reset (async assert, sync-release use): state=IDLE; s_eth_hdr_ready=0 (it is 1 from the first cycle after reset releases); tready=0; m_frame_valid=0; m_frame_data=0; m_frame_len=0; m_frame_error=0; byte index=0. Reset mid-frame discards the partial frame and emits nothing.
- Three states: IDLE, PAYLOAD, OUTPUT.
- IDLE:
  - s_eth_hdr_ready=1, tready=0.
  - On hdr valid&ready: latch the 112-bit header into m_frame_data MSBs, clear the payload region, index=0, error=0; go to PAYLOAD.
- PAYLOAD:
  - s_eth_hdr_ready=0, tready=1.
  - Each accepted beat with tkeep=1 and index<PAYLOAD_BYTES: write tdata to bits [TOTAL_WIDTH-113-8*index -: 8], then index+1.
  - Beat with tkeep=0: accepted, not stored, index unchanged.
  - Beat with tkeep=1 and index==PAYLOAD_BYTES: byte dropped, error set (long frame).
  - On the tlast beat, after that byte is applied:
    - m_frame_len = final index.
    - error |= tuser | (index < PAYLOAD_BYTES).
    - Go to OUTPUT.
  - Unwritten payload bytes stay 0.
- OUTPUT:
  - m_frame_valid=1, tready=0, s_eth_hdr_ready=0.
  - data, len and error held stable until m_frame_ready.
  - On valid&ready: m_frame_valid=0 next cycle, go to IDLE.
- Latency: m_frame_valid rises on the cycle after the tlast beat is accepted. The header of the next frame can be accepted no earlier than 1 cycle after the output handshake.
- Payload beats presented while in IDLE are not accepted (tready=0). A header presented during PAYLOAD/OUTPUT waits.
- A zero-byte frame (single tlast beat with tkeep=0) gives len=0, error=1.

Optional Feature:
- Macro ARP_FRAME_TYPE_FILTER_EN.
- Defined:
  - In IDLE, a header whose s_eth_type != FILTER_TYPE is accepted.
  - Its payload is consumed in PAYLOAD (tready=1) through tlast, but nothing is stored and OUTPUT is skipped: return to IDLE the cycle after tlast.
  - m_frame_valid never pulses for that frame.
- Undefined: every EtherType is packed and output.

Test Plan:
- ARP request: dest ff:ff:ff:ff:ff:ff, src 5a:51:52:53:54:55, type 0806, 28 bytes 00 01 08 00 06 04 00 01 5a..55 c0 a8 01 65 00×6 c0 a8 01 64, m_frame_ready=1 -> one cycle after tlast: m_frame_valid=1, m_frame_data = exact 336-bit concatenation, len=28, error=0.
- Backpressure: same frame with m_frame_ready=0 for 10 cycles -> valid/data/len stable for all 10 cycles; s_eth_hdr_ready=0 and tready=0 throughout; handshake on cycle 11; hdr_ready=1 the following cycle.
- Short frame: tlast on byte 20 -> len=20, error=1, low 64 bits of data = 0.
- Long frame / tuser: 30 bytes -> len=28, bytes 28 and 29 absent, error=1. Separately, a 28-byte frame with tuser=1 on tlast -> error=1.
- Reset mid-payload: rst_n low after byte 10 -> all outputs 0 immediately. Next full frame is packed correctly with no residue.
- Filter (macro defined): type 0800 frame then type 0806 frame -> only the second produces m_frame_valid, with type field 0806. Macro undefined: both frames output.
